// File: rtl/npc_ctrl_pkg.sv
// Shared types and constants for the next-PC redirect controller.
// Holds the FSM state encoding, the credit-counter sizing and the sequential PC step.
package npc_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REDIR = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam int MAX_OUT_DEF = 4;
   localparam logic [31:0] PC_INC = 32'd4;

   function automatic int cnt_width(input int max_out);
      return $clog2(max_out + 1);
   endfunction

   localparam int CNT_W = cnt_width(MAX_OUT_DEF);

endpackage

// File: rtl/fetch_credit_cnt.sv
// In-flight fetch bookkeeping: counts outstanding IFU requests and, after a redirect,
// how many of the already-issued (now stale) responses still have to be discarded.
module fetch_credit_cnt
   import npc_ctrl_pkg::*;
#(
   parameter int MAX_OUT = MAX_OUT_DEF,
   parameter int CW      = cnt_width(MAX_OUT)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req_fire,
   input  logic          resp_fire,
   input  logic          redir_fire,
   output logic [CW-1:0] outstanding,
   output logic [CW-1:0] kill_cnt,
   output logic [CW-1:0] kill_load
);

   localparam logic [CW-1:0] MAX_V = CW'(MAX_OUT);

   // A response returning in the redirect cycle is itself stale, so it is not left to kill.
   always_comb begin
      kill_load = outstanding;
      if (resp_fire && outstanding != '0) begin
         kill_load = outstanding - CW'(1);
      end
   end

   // Illegal request/response bursts saturate instead of wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outstanding <= '0;
      end else if (req_fire && !resp_fire && outstanding != MAX_V) begin
         outstanding <= outstanding + CW'(1);
      end else if (!req_fire && resp_fire && outstanding != '0) begin
         outstanding <= outstanding - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         kill_cnt <= '0;
      end else if (redir_fire) begin
         kill_cnt <= kill_load;
      end else if (resp_fire && kill_cnt != '0) begin
         kill_cnt <= kill_cnt - CW'(1);
      end
   end

endmodule

// File: rtl/redirect_ctrl.sv
// Branch-resolution redirect controller: detects mispredicts from the EXU, flushes the
// front end, hands the correct PC to the IFU and discards responses fetched down the wrong path.
module redirect_ctrl
   import npc_ctrl_pkg::*;
#(
   parameter int MAX_OUT = MAX_OUT_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ex_valid,
   output logic        ex_ready,
   input  logic [31:0] ex_pc,
   input  logic        ex_taken,
   input  logic [31:0] ex_target,
   input  logic        ex_pred_taken,
   input  logic [31:0] ex_pred_target,
   output logic        redir_valid,
   input  logic        redir_ready,
   output logic [31:0] redir_pc,
   output logic        flush,
   input  logic        ifu_req_fire,
   input  logic        ifu_resp_fire,
   output logic        fetch_allow,
   output logic        drop_resp,
   output logic [31:0] br_cnt,
   output logic [31:0] mis_cnt
);

   localparam int CW = cnt_width(MAX_OUT);

   state_t          state, next_state;
   logic            accept, mispredict, redir_fire;
   logic [31:0]     correct_pc;
   logic [CW-1:0]   outstanding, kill_cnt, kill_load;

   fetch_credit_cnt #(.MAX_OUT(MAX_OUT), .CW(CW)) u_credit (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_fire    (ifu_req_fire),
      .resp_fire   (ifu_resp_fire),
      .redir_fire  (redir_fire),
      .outstanding (outstanding),
      .kill_cnt    (kill_cnt),
      .kill_load   (kill_load)
   );

   always_comb begin
      mispredict = (ex_taken != ex_pred_taken) || (ex_taken && (ex_target != ex_pred_target));
      correct_pc = ex_taken ? {ex_target[31:1], 1'b0} : ex_pc + PC_INC;
   end

   // flush is gated by rst_n so a mispredict presented during reset never escapes.
   always_comb begin
      next_state  = state;
      ex_ready    = 1'b0;
      redir_valid = 1'b0;
      redir_fire  = 1'b0;
      flush       = 1'b0;
      unique case (state)
         IDLE: begin
            ex_ready = 1'b1;
            if (ex_valid && mispredict) begin
               flush      = rst_n;
               next_state = REDIR;
            end
         end
         REDIR: begin
            redir_valid = 1'b1;
            if (redir_ready) begin
               redir_fire = 1'b1;
               next_state = (kill_load != '0) ? DRAIN : IDLE;
            end
         end
         DRAIN: begin
            if (kill_cnt == '0 || (ifu_resp_fire && kill_cnt == CW'(1))) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   assign accept      = ex_valid && ex_ready;
   assign drop_resp   = (state == REDIR) || (kill_cnt != '0);
   assign fetch_allow = (outstanding < CW'(MAX_OUT)) && (state != REDIR);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         redir_pc <= '0;
         br_cnt   <= '0;
         mis_cnt  <= '0;
      end else if (accept) begin
         br_cnt <= br_cnt + 32'd1;
         if (mispredict) begin
            mis_cnt  <= mis_cnt + 32'd1;
            redir_pc <= correct_pc;
         end
      end
   end

   a_req_without_credit: assert property (@(posedge clk) disable iff (!rst_n)
      !(ifu_req_fire && !fetch_allow));
   a_resp_without_req: assert property (@(posedge clk) disable iff (!rst_n)
      !(ifu_resp_fire && outstanding == '0));

endmodule

// File: tb/tb_redirect_ctrl.sv
// Directed bench for redirect_ctrl: mispredict detection, redirect handshake,
// fetch credit limits, stale-response draining and reset behaviour.
module tb_redirect_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ex_valid, ex_ready, ex_taken, ex_pred_taken;
   logic [31:0] ex_pc, ex_target, ex_pred_target;
   logic        redir_valid, redir_ready, flush;
   logic [31:0] redir_pc;
   logic        ifu_req_fire, ifu_resp_fire, fetch_allow, drop_resp;
   logic [31:0] br_cnt, mis_cnt;

   int tests_run    = 0;
   int tests_failed = 0;

   redirect_ctrl #(.MAX_OUT(4)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .ex_valid       (ex_valid),
      .ex_ready       (ex_ready),
      .ex_pc          (ex_pc),
      .ex_taken       (ex_taken),
      .ex_target      (ex_target),
      .ex_pred_taken  (ex_pred_taken),
      .ex_pred_target (ex_pred_target),
      .redir_valid    (redir_valid),
      .redir_ready    (redir_ready),
      .redir_pc       (redir_pc),
      .flush          (flush),
      .ifu_req_fire   (ifu_req_fire),
      .ifu_resp_fire  (ifu_resp_fire),
      .fetch_allow    (fetch_allow),
      .drop_resp      (drop_resp),
      .br_cnt         (br_cnt),
      .mis_cnt        (mis_cnt)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_ex(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                           input logic ptk, input logic [31:0] ptgt);
      ex_valid       = 1'b1;
      ex_pc          = pc;
      ex_taken       = tk;
      ex_target      = tgt;
      ex_pred_taken  = ptk;
      ex_pred_target = ptgt;
   endtask

   task automatic test_reset();
      drive_ex(32'h8000_0100, 1'b1, 32'h8000_0103, 1'b0, 32'h0);
      #2;
      tests_run++; if (flush !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_flush: got %b want 0", flush); end
      tests_run++; if (redir_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_redir_valid: got %b want 0", redir_valid); end
      tests_run++; if (ex_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_ex_ready: got %b want 1", ex_ready); end
      step();
      tests_run++; if (fetch_allow !== 1'b1 || drop_resp !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_credit: got allow=%b drop=%b want 1/0", fetch_allow, drop_resp); end
      tests_run++; if (redir_pc !== 32'h0 || br_cnt !== 32'h0 || mis_cnt !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_regs: got pc=%h br=%0d mis=%0d want 0/0/0", redir_pc, br_cnt, mis_cnt); end
      ex_valid = 1'b0;
      rst_n    = 1'b1;
      step();
   endtask

   task automatic test_correct_pred();
      drive_ex(32'h8000_0000, 1'b1, 32'h8000_0040, 1'b1, 32'h8000_0040);
      #1;
      tests_run++; if (flush !== 1'b0 || ex_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL correct_taken_flush: got flush=%b ready=%b want 0/1", flush, ex_ready); end
      step();
      tests_run++; if (br_cnt !== 32'd1 || mis_cnt !== 32'd0 || redir_valid !== 1'b0 || ex_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL correct_taken_state: got br=%0d mis=%0d rv=%b ready=%b want 1/0/0/1", br_cnt, mis_cnt, redir_valid, ex_ready); end
      drive_ex(32'h8000_0044, 1'b0, 32'h1234_5678, 1'b0, 32'h8765_4320);
      #1;
      tests_run++; if (flush !== 1'b0) begin tests_failed++; $display("[TB] FAIL correct_nt_flush: got %b want 0", flush); end
      step();
      ex_valid = 1'b0;
      tests_run++; if (br_cnt !== 32'd2 || mis_cnt !== 32'd0 || redir_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL correct_nt_state: got br=%0d mis=%0d rv=%b want 2/0/0", br_cnt, mis_cnt, redir_valid); end
   endtask

   task automatic test_mispredict_stall();
      drive_ex(32'h8000_0100, 1'b1, 32'h8000_0103, 1'b0, 32'h0);
      #1;
      tests_run++; if (flush !== 1'b1) begin tests_failed++; $display("[TB] FAIL mis_taken_flush: got %b want 1", flush); end
      step();
      drive_ex(32'h0000_0200, 1'b1, 32'h0000_0300, 1'b0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         tests_run++;
         if (redir_valid !== 1'b1 || redir_pc !== 32'h8000_0102 || fetch_allow !== 1'b0 || ex_ready !== 1'b0 || flush !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL redir_stall_%0d: got rv=%b pc=%h allow=%b ready=%b flush=%b want 1/80000102/0/0/0", i, redir_valid, redir_pc, fetch_allow, ex_ready, flush);
         end
         step();
      end
      ex_valid = 1'b0;
      tests_run++; if (br_cnt !== 32'd3 || mis_cnt !== 32'd1) begin tests_failed++; $display("[TB] FAIL mis_taken_cnt: got br=%0d mis=%0d want 3/1", br_cnt, mis_cnt); end
      redir_ready = 1'b1;
      step();
      redir_ready = 1'b0;
      tests_run++; if (redir_valid !== 1'b0 || ex_ready !== 1'b1 || drop_resp !== 1'b0) begin tests_failed++; $display("[TB] FAIL redir_fire_idle: got rv=%b ready=%b drop=%b want 0/1/0", redir_valid, ex_ready, drop_resp); end
   endtask

   task automatic test_wrap();
      drive_ex(32'hFFFF_FFFC, 1'b0, 32'h0000_1000, 1'b1, 32'h0000_1000);
      #1;
      tests_run++; if (flush !== 1'b1) begin tests_failed++; $display("[TB] FAIL wrap_flush: got %b want 1", flush); end
      step();
      ex_valid    = 1'b0;
      redir_ready = 1'b1;
      tests_run++; if (redir_pc !== 32'h0000_0000 || redir_valid !== 1'b1 || mis_cnt !== 32'd2 || br_cnt !== 32'd4) begin tests_failed++; $display("[TB] FAIL wrap_pc: got pc=%h rv=%b mis=%0d br=%0d want 00000000/1/2/4", redir_pc, redir_valid, mis_cnt, br_cnt); end
      step();
      redir_ready = 1'b0;
      tests_run++; if (ex_ready !== 1'b1 || redir_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL wrap_idle: got ready=%b rv=%b want 1/0", ex_ready, redir_valid); end
   endtask

   task automatic test_credit_limit();
      ifu_req_fire = 1'b1;
      for (int i = 0; i < 3; i++) step();
      ifu_resp_fire = 1'b1;
      step();
      ifu_resp_fire = 1'b0;
      tests_run++; if (fetch_allow !== 1'b1) begin tests_failed++; $display("[TB] FAIL credit_req_resp: got allow=%b want 1", fetch_allow); end
      step();
      ifu_req_fire = 1'b0;
      tests_run++; if (fetch_allow !== 1'b0) begin tests_failed++; $display("[TB] FAIL credit_full: got allow=%b want 0", fetch_allow); end
      ifu_resp_fire = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tests_run++; if (drop_resp !== 1'b0) begin tests_failed++; $display("[TB] FAIL credit_drop_%0d: got %b want 0", i, drop_resp); end
         step();
         if (i == 0) begin
            tests_run++; if (fetch_allow !== 1'b1) begin tests_failed++; $display("[TB] FAIL credit_release: got allow=%b want 1", fetch_allow); end
         end
      end
      ifu_resp_fire = 1'b0;
   endtask

   task automatic enter_drain();
      ifu_req_fire = 1'b1;
      for (int i = 0; i < 3; i++) step();
      ifu_req_fire = 1'b0;
      drive_ex(32'h0000_1000, 1'b1, 32'h0000_2000, 1'b1, 32'h0000_3000);
      step();
      ex_valid      = 1'b0;
      redir_ready   = 1'b1;
      ifu_resp_fire = 1'b1;
      #1;
      tests_run++; if (drop_resp !== 1'b1 || redir_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL drain_redir: got drop=%b rv=%b want 1/1", drop_resp, redir_valid); end
      step();
      redir_ready   = 1'b0;
      ifu_resp_fire = 1'b0;
   endtask

   task automatic test_drain();
      enter_drain();
      tests_run++; if (redir_pc !== 32'h0000_2000 || mis_cnt !== 32'd3 || br_cnt !== 32'd5) begin tests_failed++; $display("[TB] FAIL drain_target: got pc=%h mis=%0d br=%0d want 00002000/3/5", redir_pc, mis_cnt, br_cnt); end
      tests_run++; if (drop_resp !== 1'b1 || redir_valid !== 1'b0 || ex_ready !== 1'b0 || fetch_allow !== 1'b1) begin tests_failed++; $display("[TB] FAIL drain_enter: got drop=%b rv=%b ready=%b allow=%b want 1/0/0/1", drop_resp, redir_valid, ex_ready, fetch_allow); end
      ifu_resp_fire = 1'b1;
      step();
      tests_run++; if (drop_resp !== 1'b1 || ex_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL drain_kill1: got drop=%b ready=%b want 1/0", drop_resp, ex_ready); end
      step();
      ifu_resp_fire = 1'b0;
      tests_run++; if (drop_resp !== 1'b0 || ex_ready !== 1'b1 || fetch_allow !== 1'b1) begin tests_failed++; $display("[TB] FAIL drain_done: got drop=%b ready=%b allow=%b want 0/1/1", drop_resp, ex_ready, fetch_allow); end
   endtask

   task automatic test_reset_in_drain();
      enter_drain();
      tests_run++; if (drop_resp !== 1'b1) begin tests_failed++; $display("[TB] FAIL rdrain_pre: got drop=%b want 1", drop_resp); end
      drive_ex(32'h0000_4000, 1'b1, 32'h0000_5000, 1'b0, 32'h0);
      #2;
      rst_n = 1'b0;
      #1;
      tests_run++; if (drop_resp !== 1'b0 || redir_valid !== 1'b0 || flush !== 1'b0 || ex_ready !== 1'b1 || fetch_allow !== 1'b1) begin tests_failed++; $display("[TB] FAIL rdrain_outputs: got drop=%b rv=%b flush=%b ready=%b allow=%b want 0/0/0/1/1", drop_resp, redir_valid, flush, ex_ready, fetch_allow); end
      tests_run++; if (redir_pc !== 32'h0 || br_cnt !== 32'h0 || mis_cnt !== 32'h0) begin tests_failed++; $display("[TB] FAIL rdrain_regs: got pc=%h br=%0d mis=%0d want 0/0/0", redir_pc, br_cnt, mis_cnt); end
      ex_valid = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      drive_ex(32'h0000_4000, 1'b0, 32'h0, 1'b0, 32'h0);
      step();
      ex_valid = 1'b0;
      tests_run++; if (br_cnt !== 32'd1 || mis_cnt !== 32'd0 || drop_resp !== 1'b0 || redir_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL rdrain_after: got br=%0d mis=%0d drop=%b rv=%b want 1/0/0/0", br_cnt, mis_cnt, drop_resp, redir_valid); end
   endtask

   initial begin
      rst_n          = 1'b0;
      ex_valid       = 1'b0;
      ex_pc          = '0;
      ex_taken       = 1'b0;
      ex_target      = '0;
      ex_pred_taken  = 1'b0;
      ex_pred_target = '0;
      redir_ready    = 1'b0;
      ifu_req_fire   = 1'b0;
      ifu_resp_fire  = 1'b0;
      test_reset();
      test_correct_pred();
      test_mispredict_stall();
      test_wrap();
      test_credit_limit();
      test_drain();
      test_reset_in_drain();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
